// File: rtl/quickq_pkg.sv
// Shared types for the quickQueue head controller and the quickNode chain.
// Holds the controller state encoding, default sizes and the chain command bundle.
package quickq_pkg;

   localparam int KEY_W_DEF = 16;
   localparam int DEPTH_DEF = 16;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      ENQ,
      DEQ,
      DEQ_TAIL,
      GAP
   } quickq_head_state_t;

   typedef struct packed {
      logic write;
      logic read;
      logic reset;
   } quickq_cmd_t;

endpackage

// File: rtl/quickq_shifter.sv
// Bidirectional KEY_W shift register with beat counter: parallel load + MSB-first
// serial out for enqueue, serial in from node 0 for dequeue.
module quickq_shifter #(
   parameter int KEY_W = 16
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [KEY_W-1:0] load_data_i,
   input  logic             shift_en_i,
   input  logic             ser_i,
   output logic             ser_o,
   output logic [KEY_W-1:0] shifted_o,
   output logic             last_o
);

   localparam int BEAT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

   logic [KEY_W-1:0]  sr_q, sr_d;
   logic [BEAT_W-1:0] beat_q, beat_d;

   assign ser_o     = sr_q[KEY_W-1];
   assign shifted_o = {sr_q[KEY_W-2:0], ser_i};
   assign last_o    = (beat_q == BEAT_W'(KEY_W - 1));

   always_comb begin
      sr_d   = sr_q;
      beat_d = beat_q;
      if (load_i) begin
         sr_d   = load_data_i;
         beat_d = '0;
      end else if (shift_en_i) begin
         sr_d   = shifted_o;
         beat_d = last_o ? '0 : beat_q + BEAT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) beat_q <= '0;
      else         beat_q <= beat_d;
   end

   // Key bits carry no reset: every use is preceded by a load or a full shift-in.
   always_ff @(posedge clk) begin
      sr_q <= sr_d;
   end

endmodule

// File: rtl/quickq_head.sv
// Head controller for the bit-serial quickNode chain: handshakes, serialisation,
// chain command pulses and occupancy. Optional counters under QUICKQ_HEAD_STATS_EN.
module quickq_head
   import quickq_pkg::*;
#(
   parameter  int KEY_W = KEY_W_DEF,
   parameter  int DEPTH = DEPTH_DEF,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             enq_valid_i,
   output logic             enq_ready_o,
   input  logic [KEY_W-1:0] enq_data_i,
   input  logic             deq_valid_i,
   output logic             deq_ready_o,
   output logic [KEY_W-1:0] deq_data_o,
   output logic             deq_done_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o,
   output logic             node_data_o,
   input  logic             node_data_i,
   output logic             node_write_o,
   output logic             node_read_o,
   output logic             node_reset_o
`ifdef QUICKQ_HEAD_STATS_EN
   ,
   output logic [31:0]      stat_enq_o,
   output logic [31:0]      stat_deq_o,
   output logic [31:0]      stat_drop_o
`endif
);

   quickq_head_state_t state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [KEY_W-1:0]   deq_data_q, deq_data_d;
   logic               deq_done_q, deq_done_d;
   logic               clr_rst_q, clr_rst_d;
   quickq_cmd_t        cmd;

   logic               full, empty, in_idle;
   logic               enq_fire, deq_fire;
   logic               sh_load, sh_shift, sh_ser, sh_last;
   logic [KEY_W-1:0]   sh_load_data, sh_shifted;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign in_idle = (state_q == IDLE);

   assign enq_ready_o = in_idle & ~full & ~clear_i;
   assign deq_ready_o = in_idle & ~empty & ~clear_i;
   assign deq_fire    = deq_valid_i & deq_ready_o;
   assign enq_fire    = enq_valid_i & enq_ready_o & ~deq_fire;

   assign sh_load      = enq_fire | deq_fire;
   assign sh_load_data = enq_fire ? enq_data_i : '0;
   assign sh_shift     = (state_q == ENQ) | (state_q == DEQ) | (state_q == DEQ_TAIL);

   quickq_shifter #(
      .KEY_W(KEY_W)
   ) u_shifter (
      .clk        (clk),
      .reset_i    (reset_i),
      .load_i     (sh_load),
      .load_data_i(sh_load_data),
      .shift_en_i (sh_shift),
      .ser_i      (node_data_i),
      .ser_o      (sh_ser),
      .shifted_o  (sh_shifted),
      .last_o     (sh_last)
   );

   // INIT's chain reset is masked while reset_i is held so every command idles at 0.
   always_comb begin
      cmd.write = (state_q == ENQ);
      cmd.read  = (state_q == DEQ);
      cmd.reset = ((state_q == INIT) & ~reset_i) | clr_rst_q;
   end

   assign node_write_o = cmd.write;
   assign node_read_o  = cmd.read;
   assign node_reset_o = cmd.reset;
   assign node_data_o  = cmd.write & sh_ser;

   assign deq_data_o = deq_data_q;
   assign deq_done_o = deq_done_q;
   assign full_o     = full;
   assign empty_o    = empty;
   assign count_o    = count_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      deq_data_d = deq_data_q;
      deq_done_d = 1'b0;
      clr_rst_d  = 1'b0;
      if (clear_i) begin
         state_d   = GAP;
         count_d   = '0;
         clr_rst_d = 1'b1;
      end else begin
         unique case (state_q)
            INIT: state_d = IDLE;
            IDLE: begin
               if (deq_fire)      state_d = DEQ;
               else if (enq_fire) state_d = ENQ;
            end
            ENQ: begin
               if (sh_last) begin
                  count_d = count_q + CNT_W'(1);
                  state_d = GAP;
               end
            end
            DEQ: begin
               if (sh_last) state_d = DEQ_TAIL;
            end
            // Last returned bit arrives here, one cycle after the final read beat.
            DEQ_TAIL: begin
               deq_data_d = sh_shifted;
               deq_done_d = 1'b1;
               count_d    = count_q - CNT_W'(1);
               state_d    = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = INIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= INIT;
         count_q    <= '0;
         deq_data_q <= '0;
         deq_done_q <= 1'b0;
         clr_rst_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         deq_data_q <= deq_data_d;
         deq_done_q <= deq_done_d;
         clr_rst_q  <= clr_rst_d;
      end
   end

`ifdef QUICKQ_HEAD_STATS_EN
   logic [31:0] stat_enq_q, stat_enq_d;
   logic [31:0] stat_deq_q, stat_deq_d;
   logic [31:0] stat_drop_q, stat_drop_d;

   always_comb begin
      stat_enq_d  = stat_enq_q;
      stat_deq_d  = stat_deq_q;
      stat_drop_d = stat_drop_q;
      if (clear_i) begin
         stat_enq_d  = '0;
         stat_deq_d  = '0;
         stat_drop_d = '0;
      end else begin
         if ((state_q == ENQ) && sh_last) stat_enq_d  = stat_enq_q + 32'd1;
         if (state_q == DEQ_TAIL)         stat_deq_d  = stat_deq_q + 32'd1;
         if (in_idle && enq_valid_i && full) stat_drop_d = stat_drop_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         stat_enq_q  <= '0;
         stat_deq_q  <= '0;
         stat_drop_q <= '0;
      end else begin
         stat_enq_q  <= stat_enq_d;
         stat_deq_q  <= stat_deq_d;
         stat_drop_q <= stat_drop_d;
      end
   end

   assign stat_enq_o  = stat_enq_q;
   assign stat_deq_o  = stat_deq_q;
   assign stat_drop_o = stat_drop_q;
`endif

endmodule

// File: tb/tb_quickq_head.sv
// Randomised scoreboard bench for quickq_head (KEY_W=8, DEPTH=4) with a min-priority
// chain model on the serial side and an operation-timing reference model.
module tb_quickq_head;

   localparam int KW = 8;
   localparam int DP = 4;
   localparam int CW = $clog2(DP + 1);

   logic          clk = 1'b0;
   logic          reset_i;
   logic          clear_i;
   logic          enq_valid_i;
   logic          enq_ready_o;
   logic [KW-1:0] enq_data_i;
   logic          deq_valid_i;
   logic          deq_ready_o;
   logic [KW-1:0] deq_data_o;
   logic          deq_done_o;
   logic          full_o;
   logic          empty_o;
   logic [CW-1:0] count_o;
   logic          node_data_o;
   logic          node_data_i;
   logic          node_write_o;
   logic          node_read_o;
   logic          node_reset_o;
`ifdef QUICKQ_HEAD_STATS_EN
   logic [31:0]   stat_enq_o, stat_deq_o, stat_drop_o;
`endif

   always #5 clk = ~clk;

   quickq_head #(.KEY_W(KW), .DEPTH(DP)) dut (
      .clk         (clk),
      .reset_i     (reset_i),
      .clear_i     (clear_i),
      .enq_valid_i (enq_valid_i),
      .enq_ready_o (enq_ready_o),
      .enq_data_i  (enq_data_i),
      .deq_valid_i (deq_valid_i),
      .deq_ready_o (deq_ready_o),
      .deq_data_o  (deq_data_o),
      .deq_done_o  (deq_done_o),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .count_o     (count_o),
      .node_data_o (node_data_o),
      .node_data_i (node_data_i),
      .node_write_o(node_write_o),
      .node_read_o (node_read_o),
      .node_reset_o(node_reset_o)
`ifdef QUICKQ_HEAD_STATS_EN
      ,
      .stat_enq_o  (stat_enq_o),
      .stat_deq_o  (stat_deq_o),
      .stat_drop_o (stat_drop_o)
`endif
   );

   int checks = 0;
   int failures = 0;

   // Reference model: operation timing as countdowns, key set as a queue.
   int            busy, wr_left, rd_left, tmr, cnt;
   bit            tmr_deq, nres, exp_done, deq_pend;
   logic [KW-1:0] last_deq, pend_key;
   logic [KW-1:0] refk[$];
   logic [KW-1:0] exp_enq[$];
   logic [KW-1:0] exp_deq[$];
   logic [31:0]   st_enq, st_deq, st_drop;

   // Chain model: captures serial writes, serves the smallest stored key on reads.
   logic [KW-1:0] store[$];
   logic [KW-1:0] wcap, rkey;
   int            wcnt, rbeat, prev_rbeat;
   bit            prev_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int min_index(input logic [KW-1:0] q[$]);
      int mi = 0;
      for (int i = 1; i < q.size(); i++) if (q[i] < q[mi]) mi = i;
      return mi;
   endfunction

   task automatic model_reset();
      busy = 1; wr_left = 0; rd_left = 0; tmr = 0; cnt = 0;
      tmr_deq = 0; nres = 1; exp_done = 0; deq_pend = 0;
      last_deq = '0; pend_key = '0;
      refk.delete(); exp_enq.delete(); exp_deq.delete();
      st_enq = '0; st_deq = '0; st_drop = '0;
      store.delete(); wcap = '0; rkey = '0; wcnt = 0; rbeat = 0; prev_rbeat = 0; prev_rd = 0;
   endtask

   // One clock cycle, entered and left on a falling edge.
   task automatic step(input bit ev, input bit dv, input logic [KW-1:0] ed, input bit cl,
                       output bit acc_e, output bit acc_d);
      logic wr, rd, rs, nd;
      bit   idle;
      int   mi;
      acc_e = 0; acc_d = 0;
      #1;
      wr = node_write_o; rd = node_read_o; rs = node_reset_o; nd = node_data_o;
      chk("count", 32'(count_o), cnt);
      chk("full", 32'(full_o), 32'(cnt == DP));
      chk("empty", 32'(empty_o), 32'(cnt == 0));
      chk("node_write", 32'(wr), 32'(wr_left > 0));
      chk("node_read", 32'(rd), 32'(rd_left > 0));
      chk("node_reset", 32'(rs), 32'(nres));
      chk("deq_done", 32'(deq_done_o), 32'(exp_done));
      chk("deq_data_hold", 32'(deq_data_o), 32'(last_deq));
      if (!wr) chk("node_data_idle", 32'(nd), 32'd0);
`ifdef QUICKQ_HEAD_STATS_EN
      chk("stat_enq", stat_enq_o, st_enq);
      chk("stat_deq", stat_deq_o, st_deq);
      chk("stat_drop", stat_drop_o, st_drop);
`endif
      if (prev_rd) node_data_i = rkey[KW-1-prev_rbeat];
      else         node_data_i = 1'($urandom_range(0, 1));
      if (rs) begin
         store.delete();
         wcnt = 0;
      end else if (wr) begin
         wcap = {wcap[KW-2:0], nd};
         wcnt++;
      end else if (wcnt > 0) begin
         chk("write_beats", 32'(wcnt), 32'(KW));
         checks++;
         if (exp_enq.size() == 0) begin
            failures++;
            $display("FAIL chain_key: unexpected write burst got %0h", wcap);
         end else begin
            logic [KW-1:0] e;
            e = exp_enq.pop_front();
            if (wcap !== e) begin
               failures++;
               $display("FAIL chain_key: got %0h expected %0h", wcap, e);
            end
         end
         store.push_back(wcap);
         wcnt = 0;
      end
      if (rd) begin
         if (rbeat == 0) begin
            checks++;
            if (store.size() == 0) begin
               failures++;
               $display("FAIL chain_read: read burst with %0d keys stored, expected at least 1", store.size());
               rkey = '0;
            end else begin
               mi = min_index(store);
               rkey = store[mi];
               store.delete(mi);
            end
         end
         prev_rbeat = rbeat;
         rbeat = (rbeat + 1) % KW;
         prev_rd = 1;
      end else begin
         prev_rd = 0;
         rbeat = 0;
      end

      enq_valid_i = ev; deq_valid_i = dv; enq_data_i = ed; clear_i = cl;
      #1;
      idle = (busy == 0);
      chk("enq_ready", 32'(enq_ready_o), 32'(idle && !cl && cnt < DP));
      chk("deq_ready", 32'(deq_ready_o), 32'(idle && !cl && cnt > 0));

      exp_done = 0;
      if (cl) begin
         cnt = 0; busy = 1; wr_left = 0; rd_left = 0; tmr = 0; nres = 1;
         if (deq_pend) begin
            void'(exp_deq.pop_back());
            deq_pend = 0;
         end
         refk.delete(); exp_enq.delete();
         st_enq = '0; st_deq = '0; st_drop = '0;
      end else begin
         nres = 0;
         if (idle && ev && cnt == DP) st_drop++;
         if (wr_left > 0) wr_left--;
         if (rd_left > 0) rd_left--;
         if (busy > 0) busy--;
         if (tmr > 0) begin
            tmr--;
            if (tmr == 0) begin
               if (tmr_deq) begin
                  cnt--; st_deq++; exp_done = 1; last_deq = pend_key; deq_pend = 0;
               end else begin
                  cnt++; st_enq++;
               end
            end
         end
         if (idle) begin
            if (dv && cnt > 0) begin
               busy = KW + 2; rd_left = KW; tmr = KW + 1; tmr_deq = 1;
               mi = min_index(refk);
               pend_key = refk[mi];
               refk.delete(mi);
               exp_deq.push_back(pend_key);
               deq_pend = 1; acc_d = 1;
            end else if (ev && cnt < DP) begin
               busy = KW + 1; wr_left = KW; tmr = KW; tmr_deq = 0;
               refk.push_back(ed);
               exp_enq.push_back(ed);
               acc_e = 1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      bit ae, ad;
      repeat (n) step(1'b0, 1'b0, '0, 1'b0, ae, ad);
   endtask

   task automatic enq(input logic [KW-1:0] k);
      bit ae, ad;
      int n = 0;
      do begin
         step(1'b1, 1'b0, k, 1'b0, ae, ad);
         n++;
      end while (!ae && n < 60);
      checks++;
      if (!ae) begin
         failures++;
         $display("FAIL enq_accept: key %0h pending after %0d cycles, expected accept", k, n);
      end
   endtask

   task automatic deq();
      bit ae, ad;
      int n = 0;
      do begin
         step(1'b0, 1'b1, '0, 1'b0, ae, ad);
         n++;
      end while (!ad && n < 60);
      checks++;
      if (!ad) begin
         failures++;
         $display("FAIL deq_accept: pending after %0d cycles, expected accept", n);
      end
   endtask

   task automatic do_reset(input int n);
      reset_i = 1'b1;
      enq_valid_i = 1'b0; deq_valid_i = 1'b0; clear_i = 1'b0;
      repeat (n) begin
         #1;
         chk("rst_count", 32'(count_o), 32'd0);
         chk("rst_empty", 32'(empty_o), 32'd1);
         chk("rst_full", 32'(full_o), 32'd0);
         chk("rst_enq_ready", 32'(enq_ready_o), 32'd0);
         chk("rst_deq_ready", 32'(deq_ready_o), 32'd0);
         chk("rst_cmds", 32'({node_write_o, node_read_o, node_reset_o, node_data_o}), 32'd0);
         chk("rst_deq_done", 32'(deq_done_o), 32'd0);
         chk("rst_deq_data", 32'(deq_data_o), 32'd0);
`ifdef QUICKQ_HEAD_STATS_EN
         chk("rst_stats", stat_enq_o | stat_deq_o | stat_drop_o, 32'd0);
`endif
         @(negedge clk);
      end
      reset_i = 1'b0;
      model_reset();
   endtask

   // Scoreboard monitor: every completed dequeue is matched against the queued expectation.
   always @(negedge clk) begin : deq_monitor
      logic [KW-1:0] e;
      if (!reset_i && deq_done_o) begin
         checks++;
         if (exp_deq.size() == 0) begin
            failures++;
            $display("FAIL deq_scoreboard: unexpected deq_done with data %0h", deq_data_o);
         end else begin
            e = exp_deq.pop_front();
            if (deq_data_o !== e) begin
               failures++;
               $display("FAIL deq_scoreboard: got %0h expected %0h", deq_data_o, e);
            end
         end
      end
   end

   initial begin
      bit ae, ad;
      reset_i = 1'b1; clear_i = 1'b0; enq_valid_i = 1'b0; deq_valid_i = 1'b0;
      enq_data_i = '0; node_data_i = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset(3);

      // INIT cycle then basic enqueue of 0xA5
      idle_cycles(2);
      enq(8'hA5);
      idle_cycles(12);

      // fill to capacity then hold enq_valid while full
      enq(8'h10); enq(8'hF0); enq(8'h42);
      repeat (20) step(1'b1, 1'b0, 8'h77, 1'b0, ae, ad);
      repeat (4) deq();
      idle_cycles(12);

      // single enqueue / dequeue of 0x3C
      enq(8'h3C);
      deq();
      idle_cycles(12);

      // both valid with count 2: dequeue wins, enqueue follows
      enq(8'h55); enq(8'h22);
      idle_cycles(12);
      begin
         int n = 0;
         do begin
            step(1'b1, 1'b1, 8'h99, 1'b0, ae, ad);
            n++;
         end while (!ae && n < 60);
      end
      idle_cycles(12);

      // clear at read beat 3
      deq();
      idle_cycles(3);
      step(1'b0, 1'b0, '0, 1'b1, ae, ad);
      idle_cycles(12);

      // reset in the middle of an enqueue
      enq(8'hC3);
      idle_cycles(3);
      do_reset(2);
      idle_cycles(3);

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
              8'($urandom), ($urandom_range(0, 99) == 0), ae, ad);
      end
      idle_cycles(30);
      chk("deq_scoreboard_drained", 32'(exp_deq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
